// File: rtl/inst_rom_responder_pkg.sv
// inst_rom_responder_pkg
// Shared definitions for the instruction-fetch responder: FSM state
// encoding, the NOP returned for misaligned fetches, word geometry and the
// width of the memory-latency counter.
package inst_rom_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } rom_state_e;

    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam int          BYTES_PER_WORD = 4;

    // Counts 0..MEM_LAT-1; MEM_LAT is at most 4.
    localparam int          LAT_CNT_W      = 2;

endpackage

// File: rtl/inst_rom_responder_hit_buf.sv
// inst_hit_buf
// One-entry buffer remembering the last word fetched from memory, so a
// repeated fetch of the same address completes without memory traffic.
// Ports:
//   clk, rst         clock, synchronous active-low reset (invalidates entry)
//   we_i             store addr_i/word_i as the new entry
//   addr_i, word_i   address and word of a completed memory fetch
//   lookup_addr_i    address of the request being looked up
//   hit_o            entry valid and address matches lookup_addr_i
//   word_o           stored word
module inst_hit_buf #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           word_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                  hit_o,
    output logic [31:0]           word_o
);

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           word_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            word_q  <= word_i;
        end
    end

    assign hit_o  = valid_q && (addr_q == lookup_addr_i);
    assign word_o = word_q;

endmodule

// File: rtl/inst_rom_responder.sv
// inst_rom_responder
// Serves CPU instruction fetches from a byte-wide synchronous memory. Each
// aligned fetch reads four bytes one at a time (little-endian) and returns
// the assembled word with a one-cycle rom_valid_o pulse; rom_busy_o stalls
// the fetch stage meanwhile. Misaligned fetches return a NOP immediately and
// set the sticky misalign_o flag.
// Optional feature macro: INST_ROM_HIT_BUF_EN adds a one-entry buffer of the
// last memory-fetched word; a repeat fetch of that address completes at once.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   rom_ce_i, rom_addr_i      fetch request and byte address (held until valid)
//   rom_data_o, rom_valid_o   returned word and its one-cycle strobe
//   rom_busy_o                stall request to the fetch stage
//   misalign_o                sticky misaligned-fetch flag
//   mem_re_o, mem_addr_o      memory read strobe and byte address
//   mem_rdata_i               memory read data, MEM_LAT cycles after mem_re_o
// Handshake: a request is taken when rom_ce_i is high in IDLE; the requester
// keeps rom_ce_i and rom_addr_i steady until rom_valid_o. Dropping rom_ce_i
// before the word is delivered abandons the fetch with no valid pulse.
module inst_rom_responder
    import inst_rom_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    output logic                  rom_valid_o,
    output logic                  rom_busy_o,
    output logic                  misalign_o,
    output logic                  mem_re_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [7:0]            mem_rdata_i
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);
    localparam logic [1:0]           IDX_LAST = 2'(BYTES_PER_WORD - 1);

    rom_state_e            state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [LAT_CNT_W-1:0]  lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [23:0]           word_q, word_d;   // bytes 0..2 of the word in flight
    logic [31:0]           data_q, data_d;
    logic                  mis_q, mis_d;

    logic                  byte_ready;
    logic                  fetch_done;
    logic [31:0]           fetched_word;
    logic                  buf_hit;
    logic [31:0]           buf_word;

    // Address bits above the memory width are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^rom_addr_i[31:ADDR_WIDTH];

    // Last latency cycle of a still-requested fetch: mem_rdata_i is valid now.
    assign byte_ready   = (state_q == ST_WAIT) && rom_ce_i && (lat_q == LAT_LAST);
    assign fetch_done   = byte_ready && (idx_q == IDX_LAST);
    assign fetched_word = {mem_rdata_i, word_q};

`ifdef INST_ROM_HIT_BUF_EN
    inst_hit_buf #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hit_buf (
        .clk           (clk),
        .rst           (rst),
        .we_i          (fetch_done),
        .addr_i        (base_q),
        .word_i        (fetched_word),
        .lookup_addr_i (rom_addr_i[ADDR_WIDTH-1:0]),
        .hit_o         (buf_hit),
        .word_o        (buf_word)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            base_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            base_q  <= base_d;
            word_q  <= word_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        base_d  = base_q;
        word_d  = word_q;
        data_d  = data_q;
        mis_d   = mis_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rom_ce_i) begin
                    base_d = rom_addr_i[ADDR_WIDTH-1:0];
                    idx_d  = '0;
                    lat_d  = '0;
                    if (rom_addr_i[1:0] != 2'b00) begin
                        data_d  = INST_NOP;
                        mis_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (buf_hit) begin
                        data_d  = buf_word;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                lat_d   = '0;
                state_d = rom_ce_i ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                // Abort wins over capture: the in-flight byte is dropped.
                if (!rom_ce_i) begin
                    state_d = ST_IDLE;
                end else if (fetch_done) begin
                    data_d  = fetched_word;
                    state_d = ST_DONE;
                end else if (byte_ready) begin
                    unique case (idx_q)
                        2'd0:    word_d[7:0]   = mem_rdata_i;
                        2'd1:    word_d[15:8]  = mem_rdata_i;
                        default: word_d[23:16] = mem_rdata_i;
                    endcase
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_ISSUE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_re_o    = (state_q == ST_ISSUE);
    // Base plus index wraps naturally modulo 2^ADDR_WIDTH.
    assign mem_addr_o  = mem_re_o ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
    assign rom_valid_o = (state_q == ST_DONE);
    assign rom_data_o  = data_q;
    assign misalign_o  = mis_q;
    // Gated by rst so every output reads 0 while reset is held, even if a
    // request is pending.
    assign rom_busy_o  = rst && (((state_q == ST_IDLE) && rom_ce_i) ||
                                 (state_q == ST_ISSUE) || (state_q == ST_WAIT));

endmodule

// File: tb/tb_inst_rom_responder.sv
module tb_inst_rom_responder;

  localparam int          AW       = 17;
  localparam int          LAT      = 1;
  localparam int          FULL_LAT = 4 * (LAT + 1) + 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   rom_data;
  logic          rom_valid;
  logic          rom_busy;
  logic          misalign;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;

  always #5 clk = ~clk;

  inst_rom_responder #(
    .ADDR_WIDTH (AW),
    .MEM_LAT    (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (ce),
    .rom_addr_i  (addr),
    .rom_data_o  (rom_data),
    .rom_valid_o (rom_valid),
    .rom_busy_o  (rom_busy),
    .misalign_o  (misalign),
    .mem_re_o    (mem_re),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata)
  );

  // ---------------- memory model ----------------
  logic [7:0]     mem [0:(1<<AW)-1];
  logic [LAT-1:0] pv;
  logic [AW-1:0]  pa [LAT];

  always @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      pv[0] <= mem_re;
      pa[0] <= mem_addr;
    end
  end

  // Garbage when no read is due, so a wrong capture time shows up.
  assign mem_rdata = pv[LAT-1] ? mem[pa[LAT-1]] : 8'hEE;

  // ---------------- scoreboard / reference model ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  logic          exp_mis   = 1'b0;
  logic [31:0]   last_word = '0;
  logic          buf_v = 1'b0;
  logic [AW-1:0] buf_a = '0;
  logic [31:0]   buf_w = '0;

  // Expected outcome of a completed fetch of byte address a.
  task automatic model_fetch(input logic [31:0] a, output int e_lat, output logic [31:0] e_word);
    logic [AW-1:0] b;
    b = a[AW-1:0];
    exp_q.delete();
    if (a[1:0] != 2'b00) begin
      e_lat   = 1;
      e_word  = NOP;
      exp_mis = 1'b1;
    end
`ifdef INST_ROM_HIT_BUF_EN
    else if (buf_v && buf_a == b) begin
      e_lat  = 1;
      e_word = buf_w;
    end
`endif
    else begin
      e_lat  = FULL_LAT;
      e_word = '0;
      for (int i = 0; i < 4; i++) begin
        logic [AW-1:0] ba;
        ba = b + AW'(i);
        exp_q.push_back(ba);
        e_word[8*i +: 8] = mem[ba];
      end
      buf_v = 1'b1;
      buf_a = b;
      buf_w = e_word;
    end
    last_word = e_word;
  endtask

  // ---------------- drivers ----------------
  // Presents a request in the next cycle and watches until rom_valid_o.
  // Returns with rom_ce_i still high, at the falling edge of the DONE cycle.
  task automatic run_fetch(input logic [31:0] a, output int lat, output logic [31:0] d,
                           output int busy_cycles);
    @(posedge clk);
    #1;
    ce   = 1'b1;
    addr = a;
    lat  = -1;
    d    = 32'hDEAD_BEEF;
    busy_cycles = 0;
    got_q.delete();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rom_busy) busy_cycles++;
      if (mem_re) got_q.push_back(mem_addr);
      if (rom_valid) begin
        lat = k;
        d   = rom_data;
        break;
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ce   = 1'b1;
    addr = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rom_data, rom_valid, rom_busy, misalign, mem_re, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b busy=%b mis=%b re=%b maddr=%h, want all 0",
               rom_data, rom_valid, rom_busy, misalign, mem_re, mem_addr);
    end
    #1;
    rst = 1'b1;
    ce  = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_basic();
    int lat, bc, e_lat;
    logic [31:0] d, e_w;
    model_fetch(32'h0, e_lat, e_w);
    run_fetch(32'h0, lat, d, bc);
    n_tests++;
    if (d !== 32'h0010_0513 || d !== e_w) begin
      n_fail++;
      $display("FAIL basic_data: got %h want %h", d, 32'h0010_0513);
    end
    n_tests++;
    if (lat !== FULL_LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", lat, FULL_LAT);
    end
    n_tests++;
    if (bc !== FULL_LAT) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", bc, FULL_LAT);
    end
    n_tests++;
    if (got_q !== exp_q) begin
      n_fail++;
      $display("FAIL basic_mem_addrs: got %p want %p", got_q, exp_q);
    end
    go_idle();
    @(negedge clk);
    n_tests++;
    if (rom_valid !== 1'b0 || rom_busy !== 1'b0 || rom_data !== e_w) begin
      n_fail++;
      $display("FAIL basic_after_done: got v=%b busy=%b data=%h want v=0 busy=0 data=%h",
               rom_valid, rom_busy, rom_data, e_w);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, e_lat;
    logic [31:0] d, e_w;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_0104;
    addrs[1] = 32'h0000_0208;
    for (int i = 0; i < 2; i++) begin
      model_fetch(addrs[i], e_lat, e_w);
      run_fetch(addrs[i], lat, d, bc);
      n_tests++;
      if (lat !== e_lat || d !== e_w || got_q !== exp_q) begin
        n_fail++;
        $display("FAIL b2b_fetch%0d: got lat=%0d data=%h want lat=%0d data=%h", i, lat, d, e_lat, e_w);
      end
    end
    go_idle();
  endtask

  task automatic test_random();
    int lat, bc, e_lat;
    logic [31:0] d, e_w, a;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      a[1:0] = 2'b00;
      model_fetch(a, e_lat, e_w);
      run_fetch(a, lat, d, bc);
      n_tests++;
      if (lat !== e_lat || d !== e_w || bc !== e_lat || got_q !== exp_q) begin
        n_fail++;
        $display("FAIL random_fetch addr=%h: got lat=%0d data=%h busy=%0d want lat=%0d data=%h busy=%0d",
                 a, lat, d, bc, e_lat, e_w, e_lat);
      end
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  task automatic test_wrap();
    int lat, bc, e_lat;
    logic [31:0] d, e_w;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0001_FFFC;
    addrs[1] = 32'h0002_0000;
    for (int i = 0; i < 2; i++) begin
      model_fetch(addrs[i], e_lat, e_w);
      run_fetch(addrs[i], lat, d, bc);
      n_tests++;
      if (lat !== e_lat || d !== e_w || got_q !== exp_q) begin
        n_fail++;
        $display("FAIL wrap_fetch addr=%h: got lat=%0d data=%h addrs=%p want lat=%0d data=%h addrs=%p",
                 addrs[i], lat, d, got_q, e_lat, e_w, exp_q);
      end
      go_idle();
    end
  endtask

  task automatic test_misalign();
    int lat, bc, e_lat;
    logic [31:0] d, e_w;
    model_fetch(32'h6, e_lat, e_w);
    run_fetch(32'h6, lat, d, bc);
    n_tests++;
    if (d !== NOP || lat !== 1 || bc !== 1 || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL misalign_fetch: got data=%h lat=%0d busy=%0d reads=%0d want %h 1 1 0",
               d, lat, bc, got_q.size(), NOP);
    end
    n_tests++;
    if (misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_flag: got %b want 1", misalign);
    end
    go_idle();
    model_fetch(32'h8, e_lat, e_w);
    run_fetch(32'h8, lat, d, bc);
    n_tests++;
    if (misalign !== exp_mis || d !== e_w || lat !== e_lat) begin
      n_fail++;
      $display("FAIL misalign_sticky: got mis=%b data=%h lat=%0d want mis=%b data=%h lat=%0d",
               misalign, d, lat, exp_mis, e_w, e_lat);
    end
    go_idle();
  endtask

  task automatic test_abort();
    int nre, lat, bc, e_lat;
    logic seen;
    logic [31:0] d, e_w;
    @(posedge clk);
    #1;
    ce   = 1'b1;
    addr = 32'h0000_0040;
    nre  = 0;
    for (int k = 0; k < 40 && nre < 2; k++) begin
      @(negedge clk);
      if (mem_re) nre++;
    end
    n_tests++;
    if (nre !== 2) begin
      n_fail++;
      $display("FAIL abort_reach_byte1: got %0d reads want 2", nre);
    end
    @(posedge clk);
    #1;
    ce = 1'b0;
    @(negedge clk);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rom_valid | rom_busy | mem_re;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got activity=%b want 0", seen);
    end
    n_tests++;
    if (rom_data !== last_word) begin
      n_fail++;
      $display("FAIL abort_data_hold: got %h want %h", rom_data, last_word);
    end
    model_fetch(32'h0000_0040, e_lat, e_w);
    run_fetch(32'h0000_0040, lat, d, bc);
    n_tests++;
    if (lat !== e_lat || d !== e_w || got_q !== exp_q) begin
      n_fail++;
      $display("FAIL abort_refetch: got lat=%0d data=%h want lat=%0d data=%h", lat, d, e_lat, e_w);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int lat, bc, e_lat;
    logic [31:0] d, e_w;
    @(posedge clk);
    #1;
    ce   = 1'b1;
    addr = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rom_data, rom_valid, rom_busy, misalign, mem_re, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got data=%h v=%b busy=%b mis=%b re=%b maddr=%h, want all 0",
               rom_data, rom_valid, rom_busy, misalign, mem_re, mem_addr);
    end
    #1;
    rst = 1'b1;
    ce  = 1'b0;
    exp_mis   = 1'b0;
    buf_v     = 1'b0;
    last_word = '0;
    model_fetch(32'h0, e_lat, e_w);
    run_fetch(32'h0, lat, d, bc);
    n_tests++;
    if (lat !== FULL_LAT || d !== e_w || got_q !== exp_q || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_refetch: got lat=%0d data=%h mis=%b want lat=%0d data=%h mis=0",
               lat, d, misalign, FULL_LAT, e_w);
    end
    go_idle();
  endtask

`ifdef INST_ROM_HIT_BUF_EN
  task automatic test_hit_buf();
    int lat, bc, e_lat;
    logic [31:0] d, e_w;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0;
    addrs[1] = 32'h0;
    addrs[2] = 32'h4;
    for (int i = 0; i < 3; i++) begin
      model_fetch(addrs[i], e_lat, e_w);
      run_fetch(addrs[i], lat, d, bc);
      n_tests++;
      if (lat !== e_lat || d !== e_w || bc !== e_lat || got_q !== exp_q) begin
        n_fail++;
        $display("FAIL hit_buf_fetch%0d: got lat=%0d data=%h reads=%0d want lat=%0d data=%h reads=%0d",
                 i, lat, d, got_q.size(), e_lat, e_w, exp_q.size());
      end
      go_idle();
    end
    n_tests++;
    if (lat !== FULL_LAT) begin
      n_fail++;
      $display("FAIL hit_buf_miss_after: got lat=%0d want %0d", lat, FULL_LAT);
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'h10;
    mem[3] = 8'h00;

    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_wrap();
    test_misalign();
    test_abort();
    test_reset_mid();
`ifdef INST_ROM_HIT_BUF_EN
    test_hit_buf();
`endif
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_responder.md
# inst_rom_responder

Responder for the CPU instruction-fetch port: accepts word fetch requests on `rom_ce_i`/`rom_addr_i` and returns 32-bit instructions from a byte-wide synchronous memory. It assembles each word from four sequential byte reads and raises `rom_busy_o` so the CPU's fetch stage can stall. It sits between the CPU top and the external program memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: byte address width of the backing memory.
- `MEM_LAT`, 1: cycles from `mem_re_o` to a valid `mem_rdata_i`. Legal range is 1..4.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-low.
- `rom_ce_i`, in, 1: fetch request, held high until `rom_valid_o`.
- `rom_addr_i`, in, 32: byte address of the instruction, held stable while `rom_busy_o` is high.
- `rom_data_o`, out, 32: instruction word.
- `rom_valid_o`, out, 1: one-cycle pulse, `rom_data_o` valid.
- `rom_busy_o`, out, 1: stall request to the fetch stage.
- `misalign_o`, out, 1: sticky misaligned-fetch flag.
- `mem_re_o`, out, 1: memory read strobe.
- `mem_addr_o`, out, ADDR_WIDTH: memory byte address.
- `mem_rdata_i`, in, 8: memory read data.

## Operation
- FSM states:
  - IDLE: a request is accepted when `rom_ce_i`=1; the FSM latches the address.
    - Misaligned address (bits [1:0] nonzero): go to DONE with NOP 32'h00000013 and set `misalign_o`.
    - Buffer hit: go to DONE (see Configuration).
    - Otherwise: go to ISSUE with byte index 0.
  - ISSUE: drive `mem_re_o`=1 and `mem_addr_o`=(base+idx) mod 2^ADDR_WIDTH for one cycle, then go to WAIT.
  - WAIT: count MEM_LAT cycles, then capture the byte into bits [8·idx+7:8·idx] (little-endian).
    - If idx<3: increment idx and return to ISSUE.
    - If idx=3: go to DONE.
  - DONE: pulse `rom_valid_o` for one cycle and return to IDLE.
- Address bits above ADDR_WIDTH are ignored. Address wrap-around is modulo 2^ADDR_WIDTH.
- `rom_busy_o` = (IDLE & `rom_ce_i`) | ISSUE | WAIT. It is low in DONE and in IDLE without a request.
- Abort: if `rom_ce_i` drops in ISSUE or WAIT, the FSM returns to IDLE on the next edge. No valid pulse is produced, the buffer is not updated, and any byte already in flight is discarded.
- `rom_data_o` holds the last delivered word until the next DONE.
- `misalign_o` stays set until reset.
- Reset at any time, including mid-fetch: on the next edge the FSM is in IDLE and all outputs are 0, including `rom_data_o`, `mem_addr_o` and `misalign_o`. The idx and latency counters are 0 and the buffer is invalidated.

## Timing
- Request accepted in cycle T (IDLE, `rom_ce_i`=1).
- Memory fetch:
  - Byte i is issued in cycle T+1+i·(MEM_LAT+1).
  - `rom_valid_o`=1 in cycle T+4·(MEM_LAT+1)+1.
  - With MEM_LAT=1, a fetch takes 9 cycles.
- Hit or misaligned request: `rom_valid_o` in T+1; `rom_busy_o` is high only in T.
- Back-to-back: a new request can be accepted in the cycle after DONE.
- Only one `mem_re_o` is outstanding at a time; no pipelined issue.

## Configuration
- `INST_ROM_HIT_BUF_EN`
  - Defined: a one-entry buffer holds the {valid, address, word} of the last completed memory fetch. An aligned request whose address equals the buffered address completes via DONE with no memory access. The buffer is invalidated by reset.
  - Undefined: every aligned request performs four memory reads, and no buffer registers exist.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/ISSUE/WAIT/DONE);
  - `INST_NOP` = 32'h00000013;
  - `BYTES_PER_WORD` = 4;
  - the MEM_LAT counter width.
- One sub-module, `inst_hit_buf`, is instantiated only under `INST_ROM_HIT_BUF_EN`.
  - Inputs: write-enable, address, word.
  - Outputs: hit and stored word.

## Test plan
- Memory holds bytes 0x13,0x05,0x10,0x00 at addresses 0x0..0x3; fetch of 0x0 with MEM_LAT=1 -> `rom_data_o`=32'h00100513, valid in T+9, `rom_busy_o` high T..T+8, four `mem_re_o` pulses at addresses 0,1,2,3.
- Fetch of 0x6 -> valid in T+1 with 32'h00000013, `misalign_o`=1 and sticky, no `mem_re_o`.
- With `INST_ROM_HIT_BUF_EN`, fetch 0x0 then fetch 0x0 again -> second fetch valid in T+1, no `mem_re_o`; fetch 0x4 next -> full memory fetch.
- `rom_ce_i` dropped during the WAIT after byte 1 -> IDLE next cycle, no valid pulse; a re-request of 0x0 does a full four-byte fetch.
- `rst`=0 asserted mid-fetch -> all outputs 0 next cycle; after release, a fetch of 0x0 completes normally with no buffer hit.
- ADDR_WIDTH=17, fetch of 0x0001FFFC -> bytes read at 0x1FFFC..0x1FFFF; fetch of 0x0002_0000 -> reads 0x00000..0x00003.
